// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // 10^n evaluated at elaboration; 64 bits covers 10^10 for the widest config.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single BCD digit adjust step of double-dabble: add 3 when the digit is 5 or more.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_in,
  output logic [BCD_DIGIT_W-1:0] d_out_c
);

  always_comb begin
    d_out_c = (d_in >= BCD_DIGIT_W'(5)) ? (d_in + BCD_DIGIT_W'(3)) : d_in;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, with saturation.
// Define BIN2BCD_SIGNED_EN for two's-complement input and the neg output.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
`ifdef BIN2BCD_SIGNED_EN
  ,
  output logic                          neg
`endif
);

  localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SH_W  = ACC_W + WIDTH;
  localparam longint unsigned MAX_MAG = pow10(DIGITS) - 64'd1;
  localparam logic [ACC_W-1:0] SAT_BCD = {DIGITS{4'h9}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ACC_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
`ifdef BIN2BCD_SIGNED_EN
  logic             neg_pend_q, neg_pend_d;
  logic             neg_q, neg_d;
`endif

  logic [WIDTH-1:0] mag_c;
  logic [ACC_W-1:0] acc_adj_c;
  logic [SH_W-1:0]  shifted_c;
  logic             last_bit_c;

`ifdef BIN2BCD_SIGNED_EN
  always_comb begin
    mag_c = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;
  end
`else
  always_comb begin
    mag_c = bin_in;
  end
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .d_in   (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_out_c(acc_adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Bits leaving the top digit fall off the end of the shift.
  always_comb begin
    shifted_c  = {acc_adj_c, sr_q} << 1;
    last_bit_c = (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; results land on the edge entering DONE.
  always_comb begin
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = mag_c;
          acc_d      = '0;
          cnt_d      = CNT_W'(WIDTH);
          ovf_pend_d = (64'(mag_c) > MAX_MAG);
          busy_d     = 1'b1;
`ifdef BIN2BCD_SIGNED_EN
          neg_pend_d = bin_in[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        acc_d = shifted_c[SH_W-1 -: ACC_W];
        sr_d  = shifted_c[WIDTH-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (last_bit_c) begin
          done_d = 1'b1;
          bcd_d  = ovf_pend_q ? SAT_BCD : shifted_c[SH_W-1 -: ACC_W];
          ovf_d  = ovf_pend_q;
`ifdef BIN2BCD_SIGNED_EN
          neg_d  = neg_pend_q;
`endif
        end
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      acc_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
`ifdef BIN2BCD_SIGNED_EN
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
  assign neg      = neg_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: default (14/4) and small (8/2) instances.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start8;
  logic [13:0] bin_in;
  logic [7:0]  bin8;
  logic        busy, done, overflow;
  logic [15:0] bcd_out;
  logic        busy8, done8, ovf8;
  logic [7:0]  bcd8;
`ifdef BIN2BCD_SIGNED_EN
  logic        neg, neg8;
  logic        exp_neg_v;
`endif

  int          n_checks;
  int          n_fail;
  logic [15:0] last_bcd, last_bcd8;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .overflow(overflow)
`ifdef BIN2BCD_SIGNED_EN
    ,
    .neg     (neg)
`endif
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .bin_in  (bin8),
    .busy    (busy8),
    .done    (done8),
    .bcd_out (bcd8),
    .overflow(ovf8)
`ifdef BIN2BCD_SIGNED_EN
    ,
    .neg     (neg8)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_bcd(input bit sm);
    return sm ? {8'h00, bcd8} : bcd_out;
  endfunction

  function automatic logic [1:0] rd_bd(input bit sm);
    return sm ? {busy8, done8} : {busy, done};
  endfunction

  function automatic logic rd_ovf(input bit sm);
    return sm ? ovf8 : overflow;
  endfunction

  // Called in IDLE at #1 after an edge; walks the full conversion timeline.
  task automatic do_conv(input bit sm, input logic [31:0] v, input logic [15:0] eb,
                         input logic eo, input string tag);
    int unsigned w;
    logic [15:0] prev;
    w    = sm ? 8 : 14;
    prev = sm ? last_bcd8 : last_bcd;
    if (sm) begin start8 = 1'b1; bin8 = 8'(v); end
    else    begin start  = 1'b1; bin_in = 14'(v); end
    @(posedge clk); #1;
    start  = 1'b0;
    start8 = 1'b0;
    bin_in = ~14'(v);
    bin8   = ~8'(v);
    for (int k = 1; k <= int'(w); k++) begin
      chk({tag, "_busy"}, 64'(rd_bd(sm)), 64'(2'b10));
      if (k == 2) chk({tag, "_hold"}, 64'(rd_bcd(sm)), 64'(prev));
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 64'(rd_bd(sm)), 64'(2'b11));
    chk({tag, "_bcd"}, 64'(rd_bcd(sm)), 64'(eb));
    chk({tag, "_ovf"}, 64'(rd_ovf(sm)), 64'(eo));
`ifdef BIN2BCD_SIGNED_EN
    chk({tag, "_neg"}, 64'(sm ? neg8 : neg), 64'(exp_neg_v));
`endif
    @(posedge clk); #1;
    chk({tag, "_idle"}, 64'(rd_bd(sm)), 64'(2'b00));
    chk({tag, "_keep"}, 64'(rd_bcd(sm)), 64'(eb));
    if (sm) last_bcd8 = eb;
    else    last_bcd  = eb;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_bcd  = '0;
    last_bcd8 = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    start8    = 1'b0;
    bin_in    = '0;
    bin8      = '0;
`ifdef BIN2BCD_SIGNED_EN
    exp_neg_v = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_big", 64'({busy, done, overflow, bcd_out}), 64'd0);
    chk("rst_small", 64'({busy8, done8, ovf8, bcd8}), 64'd0);
`ifdef BIN2BCD_SIGNED_EN
    chk("rst_neg", 64'({neg, neg8}), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifndef BIN2BCD_SIGNED_EN
    do_conv(1'b0, 1234,  16'h1234, 1'b0, "c1234");
    do_conv(1'b0, 9999,  16'h9999, 1'b0, "c9999");
    do_conv(1'b0, 10000, 16'h9999, 1'b1, "c10000");
    do_conv(1'b0, 0,     16'h0000, 1'b0, "c0");
    do_conv(1'b0, 16383, 16'h9999, 1'b1, "cmax");
    do_conv(1'b0, 7,     16'h0007, 1'b0, "c7");
    do_conv(1'b1, 255,   16'h0099, 1'b1, "s255");
    do_conv(1'b1, 99,    16'h0099, 1'b0, "s99");
    do_conv(1'b1, 10,    16'h0010, 1'b0, "s10");
`else
    exp_neg_v = 1'b1;
    do_conv(1'b0, 32'h3FD6, 16'h0042, 1'b0, "cm42");
    do_conv(1'b0, 32'h2000, 16'h8192, 1'b0, "cm8192");
    exp_neg_v = 1'b0;
    do_conv(1'b0, 8191,     16'h8191, 1'b0, "c8191");
    do_conv(1'b0, 1234,     16'h1234, 1'b0, "c1234");
    do_conv(1'b0, 0,        16'h0000, 1'b0, "c0");
    exp_neg_v = 1'b1;
    do_conv(1'b1, 32'hFF,   16'h0001, 1'b0, "sm1");
    do_conv(1'b1, 32'h80,   16'h0099, 1'b1, "sm128");
    exp_neg_v = 1'b0;
    do_conv(1'b1, 99,       16'h0099, 1'b0, "s99");
`endif

    // Start held high: accepts every 16 cycles, values captured at E0/E16/E32.
    start  = 1'b1;
    bin_in = 14'd1357;
    @(posedge clk); #1;
    for (int c = 1; c <= 47; c++) begin
      if (c % 16 == 0)       chk("strm_idle", 64'({busy, done}), 64'(2'b00));
      else if (c % 16 == 15) chk("strm_done", 64'({busy, done}), 64'(2'b11));
      else                   chk("strm_busy", 64'({busy, done}), 64'(2'b10));
      if (c == 15) chk("strm_a", 64'(bcd_out), 64'(16'h1357));
      if (c == 31) chk("strm_b", 64'(bcd_out), 64'(16'h2468));
      if (c == 47) chk("strm_c", 64'({overflow, bcd_out}), 64'(17'h08001));
      if (c == 16)      bin_in = 14'd2468;
      else if (c == 32) bin_in = 14'd8001;
      else              bin_in = 14'(c * 101);
      if (c == 47) start = 1'b0;
      @(posedge clk); #1;
    end

    // Abort with reset at cycle 7 of a conversion.
    start  = 1'b1;
    bin_in = 14'd1234;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_big", 64'({busy, done, overflow, bcd_out}), 64'd0);
    chk("arst_small", 64'({busy8, done8, ovf8, bcd8}), 64'd0);
`ifdef BIN2BCD_SIGNED_EN
    chk("arst_neg", 64'({neg, neg8}), 64'd0);
`endif
    #1;
    rst_n = 1'b1;
    last_bcd  = '0;
    last_bcd8 = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("arst_nodone", 64'({busy, done, bcd_out}), 64'd0);
    end
`ifdef BIN2BCD_SIGNED_EN
    exp_neg_v = 1'b0;
`endif
    do_conv(1'b0, 42, 16'h0042, 1'b0, "c42");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
